// File: rtl/clock_keypad_pkg.sv
// Shared types, digit map and helpers for the clock time-set keypad.
// Optional range checking is enabled by defining KEYPAD_RANGE_CHECK_EN.
package clock_keypad_pkg;

   localparam logic [3:0] DIG_10HOUR   = 4'd0;
   localparam logic [3:0] DIG_HOUR     = 4'd1;
   localparam logic [3:0] DIG_10MIN    = 4'd2;
   localparam logic [3:0] DIG_MIN      = 4'd3;
   localparam logic [3:0] DIG_10SEC    = 4'd4;
   localparam logic [3:0] DIG_SEC      = 4'd5;
   localparam logic [3:0] DIG_10DAY    = 4'd6;
   localparam logic [3:0] DIG_DAY      = 4'd7;
   localparam logic [3:0] DIG_10MONTH  = 4'd8;
   localparam logic [3:0] DIG_MONTH    = 4'd9;
   localparam logic [3:0] DIG_MILLENIA = 4'd10;
   localparam logic [3:0] DIG_CENTURY  = 4'd11;
   localparam logic [3:0] DIG_DECADE   = 4'd12;
   localparam logic [3:0] DIG_YEAR     = 4'd13;

   // Bit positions inside the conditioned input vector.
   localparam int KEY_UP   = 10;
   localparam int KEY_DOWN = 11;
   localparam int KEY_SET  = 12;
   localparam int KEY_W    = 13;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ENTRY    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_WAIT_REL = 2'd3
   } state_e;

   // Largest BCD value each digit position can legally hold.
   function automatic logic [3:0] max_digit(input logic [3:0] idx);
      logic [3:0] m;
      case (idx)
         DIG_10HOUR:  m = 4'd2;
         DIG_10MIN:   m = 4'd5;
         DIG_10SEC:   m = 4'd5;
         DIG_10DAY:   m = 4'd3;
         DIG_10MONTH: m = 4'd1;
         default:     m = 4'd9;
      endcase
      return m;
   endfunction

   // One-hot digit key vector to its BCD value.
   function automatic logic [3:0] key_to_bcd(input logic [9:0] keys);
      logic [3:0] v;
      v = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keys[i]) v = 4'(i);
      end
      return v;
   endfunction

endpackage

// File: rtl/clock_keypad_entry_debouncer.sv
// Synchroniser, shared debounce counter and rising-edge detect.
// The whole vector loads at once after it has been stable long enough.
module keypad_debouncer
   import clock_keypad_pkg::*;
#(
   parameter int W               = 13,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] raw,
   output logic [W-1:0] db,
   output logic [W-1:0] rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]     sync1_q, sync1_d;
   logic [W-1:0]     sync2_q, sync2_d;
   logic [W-1:0]     sync3_q, sync3_d;
   logic [W-1:0]     db_q, db_d;
   logic [W-1:0]     prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Shift the synchroniser and restart the count on any change.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      db_d    = db_q;
      prev_d  = db_q;
      cnt_d   = cnt_q;
      if (sync2_q != sync3_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         db_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Register all conditioning state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         db_q    <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         db_q    <= db_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db   = db_q;
   assign rise = db_q & ~prev_q;

endmodule

// File: rtl/clock_keypad_entry.sv
// Time-set keypad front end: cursor, digit-write and commit/abort strobes.
// Define KEYPAD_RANGE_CHECK_EN to reject digits above the per-position limit.
module clock_keypad_entry
   import clock_keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20,
   parameter int NUM_DIGITS      = 14
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       set_time_enable,
   input  logic       b_0,
   input  logic       b_1,
   input  logic       b_2,
   input  logic       b_3,
   input  logic       b_4,
   input  logic       b_5,
   input  logic       b_6,
   input  logic       b_7,
   input  logic       b_8,
   input  logic       b_9,
   input  logic       up,
   input  logic       down,
   output logic       entry_active,
   output logic [3:0] cursor,
   output logic       digit_wr,
   output logic [3:0] digit_val,
   output logic       key_reject,
   output logic       commit,
   output logic       abort
);

   localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);

   logic [KEY_W-1:0] raw;
   logic [KEY_W-1:0] db;
   logic [KEY_W-1:0] rise;
   logic [11:0]      keys;
   logic             multi;
   logic             set_lvl;
   logic             set_rise;
   logic [3:0]       key_val;
   logic             range_ok;

   state_e     state_q, state_d;
   logic [3:0] cursor_q, cursor_d;
   logic       digit_wr_q, digit_wr_d;
   logic [3:0] digit_val_q, digit_val_d;
   logic       key_reject_q, key_reject_d;
   logic       commit_q, commit_d;
   logic       abort_q, abort_d;

   assign raw = {set_time_enable, down, up,
                 b_9, b_8, b_7, b_6, b_5,
                 b_4, b_3, b_2, b_1, b_0};

   keypad_debouncer #(
      .W               (KEY_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb (
      .CLK  (CLK),
      .RST  (RST),
      .raw  (raw),
      .db   (db),
      .rise (rise)
   );

   assign keys     = rise[11:0] & db[11:0];
   assign multi    = |(keys & (keys - 12'd1));
   assign set_lvl  = db[KEY_SET];
   assign set_rise = rise[KEY_SET];
   assign key_val  = key_to_bcd(keys[9:0]);

`ifdef KEYPAD_RANGE_CHECK_EN
   assign range_ok = (key_val <= max_digit(cursor_q));
`else
   assign range_ok = 1'b1;
`endif

   // Next state, cursor movement and strobe requests.
   always_comb begin
      state_d      = state_q;
      cursor_d     = cursor_q;
      digit_wr_d   = 1'b0;
      digit_val_d  = 4'd0;
      key_reject_d = 1'b0;
      commit_d     = 1'b0;
      abort_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cursor_d = 4'd0;
            if (set_rise) state_d = ST_ENTRY;
         end
         ST_ENTRY: begin
            if (!set_lvl) begin
               abort_d  = 1'b1;
               state_d  = ST_IDLE;
               cursor_d = 4'd0;
            end else if (multi) begin
               key_reject_d = 1'b1;
            end else if (|keys[9:0]) begin
               if (!range_ok) begin
                  key_reject_d = 1'b1;
               end else begin
                  digit_wr_d  = 1'b1;
                  digit_val_d = key_val;
                  if (cursor_q == LAST) state_d = ST_COMMIT;
                  else cursor_d = cursor_q + 4'd1;
               end
            end else if (keys[KEY_UP]) begin
               if (cursor_q == LAST) cursor_d = 4'd0;
               else cursor_d = cursor_q + 4'd1;
            end else if (keys[KEY_DOWN]) begin
               if (cursor_q == 4'd0) cursor_d = LAST;
               else cursor_d = cursor_q - 4'd1;
            end
         end
         ST_COMMIT: begin
            commit_d = 1'b1;
            state_d  = ST_WAIT_REL;
         end
         ST_WAIT_REL: begin
            if (!set_lvl) begin
               state_d  = ST_IDLE;
               cursor_d = 4'd0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cursor_d = 4'd0;
         end
      endcase
   end

   // State, cursor and registered strobes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         cursor_q     <= 4'd0;
         digit_wr_q   <= 1'b0;
         digit_val_q  <= 4'd0;
         key_reject_q <= 1'b0;
         commit_q     <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cursor_q     <= cursor_d;
         digit_wr_q   <= digit_wr_d;
         digit_val_q  <= digit_val_d;
         key_reject_q <= key_reject_d;
         commit_q     <= commit_d;
         abort_q      <= abort_d;
      end
   end

   assign entry_active = (state_q == ST_ENTRY);
   assign cursor       = cursor_q;
   assign digit_wr     = digit_wr_q;
   assign digit_val    = digit_val_q;
   assign key_reject   = key_reject_q;
   assign commit       = commit_q;
   assign abort        = abort_q;

endmodule

// File: tb/tb_clock_keypad_entry.sv
// Directed bench for clock_keypad_entry with a short debounce window.
// Strobes are counted by a negedge monitor; expectations are hand-derived.
module tb_clock_keypad_entry;

   logic        clk;
   logic        rst;
   logic [12:0] raw;

   logic       entry_active;
   logic [3:0] cursor;
   logic       digit_wr;
   logic [3:0] digit_val;
   logic       key_reject;
   logic       commit;
   logic       abort;

   int n_tests;
   int n_fail;
   int n_wr;
   int n_rej;
   int n_commit;
   int n_abort;
   int last_val;

   clock_keypad_entry #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .NUM_DIGITS      (14)
   ) dut (
      .CLK             (clk),
      .RST             (rst),
      .set_time_enable (raw[12]),
      .b_0             (raw[0]),
      .b_1             (raw[1]),
      .b_2             (raw[2]),
      .b_3             (raw[3]),
      .b_4             (raw[4]),
      .b_5             (raw[5]),
      .b_6             (raw[6]),
      .b_7             (raw[7]),
      .b_8             (raw[8]),
      .b_9             (raw[9]),
      .up              (raw[10]),
      .down            (raw[11]),
      .entry_active    (entry_active),
      .cursor          (cursor),
      .digit_wr        (digit_wr),
      .digit_val       (digit_val),
      .key_reject      (key_reject),
      .commit          (commit),
      .abort           (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every strobe away from the active edge.
   always @(negedge clk) begin
      if (digit_wr) begin
         n_wr = n_wr + 1;
         last_val = int'(digit_val);
      end
      if (key_reject) n_rej = n_rej + 1;
      if (commit) n_commit = n_commit + 1;
      if (abort) n_abort = n_abort + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      n_wr = 0;
      n_rej = 0;
      n_commit = 0;
      n_abort = 0;
      last_val = -1;
   endtask

   task automatic press(input int k);
      raw[k] = 1'b1;
      tick(12);
      raw[k] = 1'b0;
      tick(12);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_active"}, int'(entry_active), 0);
      check({tag, "_cursor"}, int'(cursor), 0);
      check({tag, "_wr"}, int'(digit_wr), 0);
      check({tag, "_val"}, int'(digit_val), 0);
      check({tag, "_rej"}, int'(key_reject), 0);
      check({tag, "_commit"}, int'(commit), 0);
      check({tag, "_abort"}, int'(abort), 0);
   endtask

   int t1_keys [4] = '{2, 3, 5, 9};
   int t4_keys [14] = '{1, 2, 5, 9, 5, 9, 3, 1, 1, 2, 2, 0, 2, 4};

   initial begin
      n_tests = 0;
      n_fail = 0;
      clr();
      raw = '0;
      rst = 1'b1;
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(12);
      check("idle_no_entry", int'(entry_active), 0);

      // 1: enter set mode and write four digits
      raw[12] = 1'b1;
      tick(12);
      check("enter_active", int'(entry_active), 1);
      check("enter_cursor", int'(cursor), 0);
      for (int i = 0; i < 4; i++) begin
         clr();
         press(t1_keys[i]);
         check($sformatf("t1_wr%0d", i), n_wr, 1);
         check($sformatf("t1_val%0d", i), last_val, t1_keys[i]);
         check($sformatf("t1_cur%0d", i), int'(cursor), i + 1);
      end

      // 2: cursor wrap with up/down
      clr();
      for (int i = 0; i < 4; i++) press(11);
      check("t2_back0", int'(cursor), 0);
      press(11);
      check("t2_down_wrap", int'(cursor), 13);
      press(10);
      check("t2_up_wrap", int'(cursor), 0);
      press(10);
      check("t2_up1", int'(cursor), 1);
      check("t2_no_wr", n_wr, 0);
      press(11);
      check("t2_rest", int'(cursor), 0);

      // 3: digit 3 at the 10-hour position
      clr();
      press(3);
`ifdef KEYPAD_RANGE_CHECK_EN
      check("t3_rej", n_rej, 1);
      check("t3_no_wr", n_wr, 0);
      check("t3_cursor", int'(cursor), 0);
`else
      check("t3_wr", n_wr, 1);
      check("t3_val", last_val, 3);
      check("t3_no_rej", n_rej, 0);
      check("t3_cursor", int'(cursor), 1);
      press(11);
      check("t3_rest", int'(cursor), 0);
`endif

      // 4: full 14-digit entry then commit
      clr();
      for (int i = 0; i < 14; i++) press(t4_keys[i]);
      check("t4_wr", n_wr, 14);
      check("t4_last_val", last_val, 4);
      check("t4_commit", n_commit, 1);
      check("t4_rej", n_rej, 0);
      check("t4_active", int'(entry_active), 0);
      check("t4_cursor_hold", int'(cursor), 13);
      press(1);
      check("t4_wait_wr", n_wr, 14);
      check("t4_wait_rej", n_rej, 0);
      raw[12] = 1'b0;
      tick(12);
      check("t4_idle_cursor", int'(cursor), 0);
      check("t4_no_abort", n_abort, 0);
      check("t4_commit_once", n_commit, 1);

      // 5: glitch rejection and two-key reject
      raw[12] = 1'b1;
      tick(12);
      check("t5_active", int'(entry_active), 1);
      check("t5_cursor", int'(cursor), 0);
      clr();
      raw[7] = 1'b1;
      tick(2);
      raw[7] = 1'b0;
      tick(12);
      check("t5_glitch_wr", n_wr, 0);
      check("t5_glitch_rej", n_rej, 0);
      raw[1] = 1'b1;
      raw[4] = 1'b1;
      tick(12);
      raw[1] = 1'b0;
      raw[4] = 1'b0;
      tick(12);
      check("t5_multi_rej", n_rej, 1);
      check("t5_multi_wr", n_wr, 0);
      check("t5_multi_cur", int'(cursor), 0);

      // 6: abort at cursor 6, then reset during a second entry
      for (int i = 0; i < 6; i++) press(10);
      check("t6_cursor6", int'(cursor), 6);
      clr();
      raw[12] = 1'b0;
      tick(12);
      check("t6_abort", n_abort, 1);
      check("t6_active", int'(entry_active), 0);
      check("t6_cursor", int'(cursor), 0);
      check("t6_no_wr", n_wr, 0);
      raw[12] = 1'b1;
      tick(12);
      press(10);
      press(10);
      check("t6_reentry", int'(entry_active), 1);
      check("t6_cur2", int'(cursor), 2);
      clr();
      rst = 1'b1;
      tick(1);
      check_zero("t6_rst");
      raw[12] = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(12);
      check_zero("t6_post");
      check("t6_rst_abort", n_abort, 0);
      check("t6_rst_commit", n_commit, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
